// File: rtl/uart_tx_oversampled.sv
// uart_tx_oversampled
//   UART serial transmitter paced by a 16x oversampling tick. A frame is one
//   start bit (low), DBIT data bits LSB first, then SB_TICK/16 stop bits
//   (high). Every bit lasts 16 s_ticks; the stop period lasts SB_TICK s_ticks.
//
// Parameters
//   DBIT     data bits per frame (5..9)
//   SB_TICK  stop period in s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
//
// Ports
//   clk           system clock, rising edge
//   reset_n       synchronous active-low reset
//   tx_start      send request, only looked at while idle
//   s_tick        one-clk oversampling tick from the baud timer
//   tx_din        data word, captured on the accepting edge
//   tx            registered serial line, idle high
//   tx_busy       high whenever a frame is in progress
//   tx_done_tick  one-clk pulse in the last tick of the stop period
module uart_tx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // Tick counter must reach both 15 (bit period) and SB_TICK-1 (stop period).
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

  // tx_next is always the line level of the state being entered, so the
  // registered line changes on the same edge as the state.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    tx_next    = tx_reg;
    done_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        // Acceptance is not tick-aligned: the start bit can be up to one
        // tick short in absolute time.
        if (tx_start) begin
          b_next     = tx_din;
          s_next     = '0;
          state_next = START;
          tx_next    = 1'b0;
        end
      end

      START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      DATA: begin
        tx_next = b_reg[0];
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = STOP;
              tx_next    = 1'b1;
            end else begin
              n_next  = n_reg + NW'(1);
              tx_next = b_next[0];
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (s_reg == S_STOP_LAST) begin
            s_next     = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state_reg != IDLE);
  // A reset edge aborts the frame, so the final stop tick must not report done.
  assign tx_done_tick = done_next & reset_n;

endmodule

// File: tb/tb_uart_tx_oversampled.sv
// Testbench for uart_tx_oversampled. Two instances: the default one
// (DBIT=8, SB_TICK=16) for most scenarios and one with SB_TICK=32 for the
// two-stop-bit case. The reference model tracks "ticks since acceptance" and
// derives the line level arithmetically from the frame layout.
module tb_uart_tx_oversampled;

  localparam int DBIT    = 8;
  localparam int TOTAL16 = 16 * (1 + DBIT) + 16;
  localparam int TOTAL32 = 16 * (1 + DBIT) + 32;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] tx_din;
  logic       tx, tx_busy, tx_done_tick;

  logic       tx_start32;
  logic       s_tick32;
  logic [7:0] tx_din32;
  logic       tx32, tx_busy32, tx_done_tick32;

  always #5 clk = ~clk;

  uart_tx_oversampled #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .tx_din       (tx_din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  uart_tx_oversampled #(.DBIT(DBIT), .SB_TICK(32)) dut32 (
    .clk          (clk),
    .reset_n      (reset_n),
    .tx_start     (tx_start32),
    .s_tick       (s_tick32),
    .tx_din       (tx_din32),
    .tx           (tx32),
    .tx_busy      (tx_busy32),
    .tx_done_tick (tx_done_tick32)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_frames = 0;

  // Reference model state: is a frame in flight, ticks counted since the
  // accepting edge, and the captured word.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_data = '0;

  logic o_tx, o_busy, o_done, e_tx, e_busy, e_done;

  function automatic logic model_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_k / 16;
    if (idx == 0) return 1'b0;
    if (idx <= DBIT) return m_data[idx-1];
    return 1'b1;
  endfunction

  // Called with this cycle's inputs already applied (at a negedge). Samples
  // the DUT, produces the model's expectation, advances the model across the
  // coming rising edge and returns at the next negedge.
  task automatic step(output logic ot, output logic ob, output logic od,
                      output logic et, output logic eb, output logic ed);
    #1;
    ot = tx;
    ob = tx_busy;
    od = tx_done_tick;
    et = model_tx();
    eb = m_active;
    ed = reset_n && m_active && s_tick && (m_k == TOTAL16 - 1);
    if (!reset_n) begin
      if (m_active) $display("frame din=0x%02h aborted by reset at tick %0d", m_data, m_k);
      m_active = 1'b0;
    end else if (m_active) begin
      if (s_tick) begin
        m_k++;
        if (m_k == TOTAL16) begin
          m_active = 1'b0;
          n_frames++;
          $display("frame %0d din=0x%02h completed after %0d ticks", n_frames, m_data, m_k);
        end
      end
    end else if (tx_start) begin
      m_active = 1'b1;
      m_k      = 0;
      m_data   = tx_din;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    tx_start   = 1'b0;
    s_tick     = 1'b0;
    tx_din     = '0;
    tx_start32 = 1'b0;
    s_tick32   = 1'b1;
    tx_din32   = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp += 5;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", tx); end
    if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    if (tx_done_tick !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", tx_done_tick); end
    if (tx32 !== 1'b1) begin n_bad++; $display("FAIL reset_tx32 got %b want 1", tx32); end
    if (tx_busy32 !== 1'b0) begin n_bad++; $display("FAIL reset_busy32 got %b want 0", tx_busy32); end
    m_active = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int busy_cnt = 0, done_cnt = 0, done_at = -1;
    s_tick   = 1'b1;
    tx_din   = 8'hA5;
    tx_start = 1'b1;
    for (int c = 0; c < 170; c++) begin
      if (c == 1) tx_start = 1'b0;
      step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
      n_cmp += 3;
      if (o_tx !== e_tx) begin n_bad++; $display("FAIL single_tx c=%0d got %b want %b", c, o_tx, e_tx); end
      if (o_busy !== e_busy) begin n_bad++; $display("FAIL single_busy c=%0d got %b want %b", c, o_busy, e_busy); end
      if (o_done !== e_done) begin n_bad++; $display("FAIL single_done c=%0d got %b want %b", c, o_done, e_done); end
      if (o_busy === 1'b1) busy_cnt++;
      if (o_done === 1'b1) begin done_cnt++; done_at = c; end
    end
    n_cmp += 3;
    if (busy_cnt != 160) begin n_bad++; $display("FAIL single_busy_len got %0d want 160", busy_cnt); end
    if (done_cnt != 1) begin n_bad++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    if (done_at != 160) begin n_bad++; $display("FAIL single_done_at got %0d want 160", done_at); end
  endtask

  task automatic test_slow_tick();
    int low_cnt = 0, done_cnt = 0, done_off_tick = 0;
    tx_din   = 8'h00;
    tx_start = 1'b1;
    for (int c = 0; c < 660; c++) begin
      if (c == 1) tx_start = 1'b0;
      s_tick = (c % 4 == 0);
      step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
      n_cmp += 3;
      if (o_tx !== e_tx) begin n_bad++; $display("FAIL slow_tx c=%0d got %b want %b", c, o_tx, e_tx); end
      if (o_busy !== e_busy) begin n_bad++; $display("FAIL slow_busy c=%0d got %b want %b", c, o_busy, e_busy); end
      if (o_done !== e_done) begin n_bad++; $display("FAIL slow_done c=%0d got %b want %b", c, o_done, e_done); end
      if (o_tx === 1'b0) low_cnt++;
      if (o_done === 1'b1) begin
        done_cnt++;
        if (c % 4 != 0) done_off_tick++;
      end
    end
    n_cmp += 3;
    if (low_cnt != 9 * 16 * 4) begin n_bad++; $display("FAIL slow_low_len got %0d want %0d", low_cnt, 9 * 16 * 4); end
    if (done_cnt != 1) begin n_bad++; $display("FAIL slow_done_cnt got %0d want 1", done_cnt); end
    if (done_off_tick != 0) begin n_bad++; $display("FAIL slow_done_on_tick got %0d off-tick pulses want 0", done_off_tick); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0, last_done = -1, first_low = -1;
    s_tick   = 1'b1;
    tx_start = 1'b1;
    tx_din   = 8'h3C;
    for (int c = 0; c < 335; c++) begin
      if (c == 1) tx_din = 8'hC3;
      if (c == 162) begin tx_start = 1'b0; tx_din = 8'h5A; end
      step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
      n_cmp += 3;
      if (o_tx !== e_tx) begin n_bad++; $display("FAIL b2b_tx c=%0d got %b want %b", c, o_tx, e_tx); end
      if (o_busy !== e_busy) begin n_bad++; $display("FAIL b2b_busy c=%0d got %b want %b", c, o_busy, e_busy); end
      if (o_done !== e_done) begin n_bad++; $display("FAIL b2b_done c=%0d got %b want %b", c, o_done, e_done); end
      if (o_done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) last_done = c;
      end
      if (last_done >= 0 && first_low < 0 && c > last_done && o_tx === 1'b0) first_low = c;
    end
    n_cmp += 2;
    if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done_cnt got %0d want 2", done_cnt); end
    if (first_low - last_done - 1 != 1) begin
      n_bad++;
      $display("FAIL b2b_gap got %0d idle clks want 1", first_low - last_done - 1);
    end
  endtask

  task automatic test_ignore_midframe();
    int done_cnt = 0;
    logic [7:0] d;
    d        = 8'($urandom);
    s_tick   = 1'b1;
    tx_din   = d;
    tx_start = 1'b1;
    for (int c = 0; c < 175; c++) begin
      if (c == 1) tx_start = 1'b0;
      if (c == 50) begin tx_start = 1'b1; tx_din = ~d; end
      if (c == 53) tx_start = 1'b0;
      step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
      n_cmp += 3;
      if (o_tx !== e_tx) begin n_bad++; $display("FAIL ignore_tx c=%0d got %b want %b", c, o_tx, e_tx); end
      if (o_busy !== e_busy) begin n_bad++; $display("FAIL ignore_busy c=%0d got %b want %b", c, o_busy, e_busy); end
      if (o_done !== e_done) begin n_bad++; $display("FAIL ignore_done c=%0d got %b want %b", c, o_done, e_done); end
      if (o_done === 1'b1) done_cnt++;
    end
    n_cmp += 2;
    if (done_cnt != 1) begin n_bad++; $display("FAIL ignore_done_cnt got %0d want 1", done_cnt); end
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle_after got busy=%b want 0", o_busy); end
  endtask

  task automatic test_reset_midframe();
    int done_cnt = 0;
    s_tick   = 1'b1;
    tx_din   = 8'($urandom);
    tx_start = 1'b1;
    // Cycle c sits at tick c-1; data bit 3 spans ticks 64..79.
    for (int c = 0; c < 110; c++) begin
      if (c == 1) tx_start = 1'b0;
      reset_n = (c != 70);
      step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
      n_cmp += 3;
      if (o_tx !== e_tx) begin n_bad++; $display("FAIL rstmid_tx c=%0d got %b want %b", c, o_tx, e_tx); end
      if (o_busy !== e_busy) begin n_bad++; $display("FAIL rstmid_busy c=%0d got %b want %b", c, o_busy, e_busy); end
      if (o_done !== e_done) begin n_bad++; $display("FAIL rstmid_done c=%0d got %b want %b", c, o_done, e_done); end
      if (c == 71) begin
        n_cmp += 2;
        if (o_tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx_after got %b want 1", o_tx); end
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after got %b want 0", o_busy); end
      end
      if (o_done === 1'b1) done_cnt++;
    end
    n_cmp += 1;
    if (done_cnt != 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt); end
    reset_n  = 1'b1;
    done_cnt = 0;
    tx_din   = 8'($urandom);
    tx_start = 1'b1;
    for (int c = 0; c < 170; c++) begin
      if (c == 1) tx_start = 1'b0;
      step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
      n_cmp += 3;
      if (o_tx !== e_tx) begin n_bad++; $display("FAIL rstnext_tx c=%0d got %b want %b", c, o_tx, e_tx); end
      if (o_busy !== e_busy) begin n_bad++; $display("FAIL rstnext_busy c=%0d got %b want %b", c, o_busy, e_busy); end
      if (o_done !== e_done) begin n_bad++; $display("FAIL rstnext_done c=%0d got %b want %b", c, o_done, e_done); end
      if (o_done === 1'b1) done_cnt++;
    end
    n_cmp += 1;
    if (done_cnt != 1) begin n_bad++; $display("FAIL rstnext_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int done_cnt = 0;
      int guard = 0;
      tx_start = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        s_tick = ($urandom_range(0, 2) == 0);
        step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
        n_cmp += 1;
        if (o_tx !== e_tx) begin n_bad++; $display("FAIL rand_gap_tx f=%0d got %b want %b", f, o_tx, e_tx); end
      end
      tx_start = 1'b1;
      tx_din   = 8'($urandom);
      do begin
        s_tick = ($urandom_range(0, 2) == 0);
        step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
        n_cmp += 3;
        if (o_tx !== e_tx) begin n_bad++; $display("FAIL rand_tx f=%0d k=%0d got %b want %b", f, m_k, o_tx, e_tx); end
        if (o_busy !== e_busy) begin n_bad++; $display("FAIL rand_busy f=%0d k=%0d got %b want %b", f, m_k, o_busy, e_busy); end
        if (o_done !== e_done) begin n_bad++; $display("FAIL rand_done f=%0d k=%0d got %b want %b", f, m_k, o_done, e_done); end
        if (o_done === 1'b1) done_cnt++;
        // Start and data churn freely mid-frame; only the accepting edge matters.
        tx_start = 1'($urandom_range(0, 1));
        tx_din   = 8'($urandom);
        guard++;
      end while (m_active && guard < 2000);
      n_cmp += 2;
      if (guard >= 2000) begin n_bad++; $display("FAIL rand_timeout f=%0d got %0d clks want < 2000", f, guard); end
      if (done_cnt != 1) begin n_bad++; $display("FAIL rand_done_cnt f=%0d got %0d want 1", f, done_cnt); end
    end
    tx_start = 1'b0;
    s_tick   = 1'b1;
    repeat (TOTAL16 + 4) step(o_tx, o_busy, o_done, e_tx, e_busy, e_done);
    m_active = 1'b0;
  endtask

  task automatic test_stop32();
    int busy_cnt = 0, done_cnt = 0, done_at = -1, stop_cnt = 0;
    logic [7:0] d;
    logic exp;
    int k;
    d          = 8'($urandom);
    tx_din32   = d;
    tx_start32 = 1'b1;
    for (int c = 0; c < 186; c++) begin
      if (c == 1) tx_start32 = 1'b0;
      #1;
      k = c - 1;
      if (c < 1 || k >= TOTAL32) exp = 1'b1;
      else if (k < 16) exp = 1'b0;
      else if (k < 16 * (1 + DBIT)) exp = d[(k - 16) / 16];
      else exp = 1'b1;
      n_cmp += 1;
      if (tx32 !== exp) begin n_bad++; $display("FAIL stop32_tx c=%0d got %b want %b", c, tx32, exp); end
      if (tx_busy32 === 1'b1) begin
        busy_cnt++;
        if (k >= 16 * (1 + DBIT) && tx32 === 1'b1) stop_cnt++;
      end
      if (tx_done_tick32 === 1'b1) begin done_cnt++; done_at = c; end
      @(negedge clk);
    end
    $display("frame din=0x%02h on 2-stop-bit instance: busy %0d clks", d, busy_cnt);
    n_cmp += 4;
    if (busy_cnt != TOTAL32) begin n_bad++; $display("FAIL stop32_busy_len got %0d want %0d", busy_cnt, TOTAL32); end
    if (stop_cnt != 32) begin n_bad++; $display("FAIL stop32_stop_len got %0d want 32", stop_cnt); end
    if (done_cnt != 1) begin n_bad++; $display("FAIL stop32_done_cnt got %0d want 1", done_cnt); end
    if (done_at != TOTAL32) begin n_bad++; $display("FAIL stop32_done_at got %0d want %0d", done_at, TOTAL32); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_slow_tick();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_random();
    test_stop32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
